matmul_tile_engine: RTL and testbench
=====================================

// Module: matmul_tile_engine
// PURPOSE
//  Parametrised M_T x N_T tile matrix-multiply engine with AXI-Stream A/B inputs and C output.
//  Buffers A (M_T x K) and B (K x N_T), runs K MAC cycles on an M_T*N_T PE array, then streams C.
//  Signed arithmetic, optional accumulate-into-C mode, TLAST framing checks and a sticky error flag.
//  Sits between the DMA stream movers and the CSR/controller layer of the accelerator.
// PARAMETERS
//  DATA_W  32  A/B element width, signed two's complement
//  ACC_W   48  C accumulator and output width; must be >= 2*DATA_W is NOT required (wraps)
//  M_T     2   rows of A and C in the tile
//  N_T     2   columns of B and C in the tile
//  K_MAX   64  maximum inner dimension; buffer depth
// PORTS
//  clk              in   1           clock, all logic on rising edge
//  rst              in   1           asynchronous, active-high reset
//  s_axis_a_tdata   in   DATA_W      A element, row-major (i outer, k inner)
//  s_axis_a_tvalid/tready/tlast      in/out/in 1  A stream handshake and frame end
//  s_axis_b_tdata   in   DATA_W      B element, row-major (k outer, j inner)
//  s_axis_b_tvalid/tready/tlast      in/out/in 1  B stream handshake and frame end
//  m_axis_c_tdata   out  ACC_W       C element, row-major (i outer, j inner)
//  m_axis_c_tvalid/tready/tlast      out/in/out 1 C stream handshake and frame end
//  cfg_k            in   16          inner dimension K, sampled on start in IDLE
//  cfg_acc          in   1           1: C += A*B (keep previous C); 0: C = A*B; sampled with cfg_k
//  start            in   1           level; run begins on start high in IDLE
//  busy             out  1           high in every state except IDLE and DONE
//  done             out  1           high in DONE; held until start drops
//  err              out  1           sticky framing/config error; cleared on next accepted start
// BEHAVIOUR
//  Reset: state IDLE, all tready=0, tvalid=0, tlast=0, tdata=0, done=0, busy=0, err=0, C array=0.
//  Reset mid-run: immediate abort to IDLE, buffered data discarded, C array cleared.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> OUTPUT -> DONE -> IDLE.
//   IDLE: start=1 latches cfg_k/cfg_acc, clears err; if cfg_k==0 or cfg_k>K_MAX -> DONE with err=1,
//         no stream beats accepted; else -> LOAD_A. If cfg_acc=0, C array is cleared on this edge.
//   LOAD_A: a_tready=1 only here; accept exactly M_T*cfg_k beats. Leave on the M_T*cfg_k-th beat.
//         tlast on an earlier beat: err=1, rest of A zero-filled, go to LOAD_B immediately.
//         tlast missing on the final beat: err=1, still go to LOAD_B.
//   LOAD_B: b_tready=1 only here; N_T*cfg_k beats; identical tlast rules; exit -> COMPUTE.
//   COMPUTE: exactly cfg_k cycles, k=0..cfg_k-1; each cycle every PE(i,j) does
//         acc += A[i][k]*B[k][j]. Product is 2*DATA_W signed, sign-extended/truncated to ACC_W;
//         accumulate wraps modulo 2^ACC_W. Exit after k==cfg_k-1 -> OUTPUT.
//   OUTPUT: M_T*N_T beats, registered output; tvalid never depends on tready; tdata/tlast stable
//         while tvalid && !tready; next beat presented in the cycle after a handshake (no bubble
//         required, one bubble allowed). tlast=1 only on beat M_T*N_T-1. Exit on last handshake.
//   DONE: done=1; start low -> IDLE. start held high does not retrigger.
//  Latency: start high in IDLE -> a_tready high next cycle. Last B beat -> first C tvalid
//   within cfg_k+2 cycles.
//  Counters advance only on handshakes (loads/output) or per cycle (compute); all widths
//   $clog2(M_T*K_MAX)+1 etc, no wrap inside a run.
//  start toggling outside IDLE/DONE is ignored. Stream beats outside their LOAD state stall (tready=0).
// STRUCTURE
//  Package matmul_pkg: state_t enum (IDLE,LOAD_A,LOAD_B,COMPUTE,OUTPUT,DONE), index-width
//   helper functions, CFG_K_W=16 constant.
//  Sub-module mac_pe (DATA_W, ACC_W): clr, en, a, b -> acc; instantiated M_T*N_T times via generate.
//  A/B buffers as register arrays in this module; output register stage in this module.
//  SVA: no accept outside LOAD states, C stable under backpressure, tlast only with tvalid,
//   exactly cfg_k COMPUTE cycles, tvalid falls only after handshake.
// TESTING
//  M_T=N_T=2, K=3, A=[1 2 3;4 5 6], B=[1 0;0 1;1 1], cfg_acc=0 -> C beats 4,5,10,11, tlast on 4th.
//  Same run repeated with cfg_acc=1 -> C beats 8,10,20,22; err=0.
//  K=2, A={-1,2,3,-4}, B={5,-6,7,8}, random tready 30% low -> C 9,22,-13,-50, data stable on stalls.
//  A tlast on beat 2 of 6 (K=3) -> err=1, A rows zero-filled, run completes, done=1, 4 C beats.
//  cfg_k=0 and cfg_k=K_MAX+1 -> DONE next cycle, err=1, no tready asserted, no C beats.
//  rst pulse during COMPUTE -> next cycle IDLE, all outputs at reset values; fresh run gives correct C.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the tile matrix-multiply engine.
package matmul_pkg;

  localparam int CFG_K_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    OUTPUT,
    DONE
  } state_t;

  // Bits needed to index n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the count n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/matmul_tile_engine_if.sv
// A/B/C stream and control bundle between the engine and its DMA/CSR neighbours.
interface matmul_tile_engine_if import matmul_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
);
  logic signed [DATA_W-1:0] s_axis_a_tdata;
  logic                     s_axis_a_tvalid;
  logic                     s_axis_a_tready;
  logic                     s_axis_a_tlast;

  logic signed [DATA_W-1:0] s_axis_b_tdata;
  logic                     s_axis_b_tvalid;
  logic                     s_axis_b_tready;
  logic                     s_axis_b_tlast;

  logic signed [ACC_W-1:0]  m_axis_c_tdata;
  logic                     m_axis_c_tvalid;
  logic                     m_axis_c_tready;
  logic                     m_axis_c_tlast;

  logic [CFG_K_W-1:0]       cfg_k;
  logic                     cfg_acc;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
    output s_axis_a_tready,
    input  s_axis_b_tdata, s_axis_b_tvalid, s_axis_b_tlast,
    output s_axis_b_tready,
    output m_axis_c_tdata, m_axis_c_tvalid, m_axis_c_tlast,
    input  m_axis_c_tready,
    input  cfg_k, cfg_acc, start,
    output busy, done, err
  );

  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid, s_axis_a_tlast,
    input  s_axis_a_tready,
    output s_axis_b_tdata, s_axis_b_tvalid, s_axis_b_tlast,
    input  s_axis_b_tready,
    input  m_axis_c_tdata, m_axis_c_tvalid, m_axis_c_tlast,
    output m_axis_c_tready,
    output cfg_k, cfg_acc, start,
    input  busy, done, err
  );

endinterface

// File: rtl/mac_pe.sv
// Single processing element: signed multiply, resize to ACC_W, wrapping accumulate.
module mac_pe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  // Sign-extends or truncates the full product; overflow wraps modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] wrap_to_acc(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign o_acc  = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + wrap_to_acc(w_prod);
    end
  end

endmodule

// File: rtl/matmul_tile_engine.sv
// M_T x N_T tile matmul: buffers A and B from streams, runs cfg_k MAC cycles, streams C out.
module matmul_tile_engine import matmul_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int M_T    = 2,
  parameter int N_T    = 2,
  parameter int K_MAX  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  matmul_tile_engine_if.slave  bus
);

  localparam int MN    = M_T * N_T;
  localparam int CNT_W = cnt_w(((M_T > N_T) ? M_T : N_T) * K_MAX);
  localparam int KI_W  = idx_w(K_MAX);
  localparam int KC_W  = cnt_w(K_MAX);
  localparam int RI_W  = idx_w(M_T);
  localparam int BI_W  = idx_w(K_MAX * N_T);
  localparam int OI_W  = idx_w(MN);

  state_t                   r_state;
  logic [KC_W-1:0]          r_kcfg;
  logic [CNT_W-1:0]         r_cnt;
  logic [RI_W-1:0]          r_row;
  logic [KI_W-1:0]          r_col;
  logic [KI_W-1:0]          r_kc;
  logic [OI_W-1:0]          r_oi;
  logic                     r_a_tready, r_b_tready;
  logic                     r_c_tvalid, r_c_tlast;
  logic signed [ACC_W-1:0]  r_c_tdata;
  logic                     r_busy, r_done, r_err;
  logic signed [DATA_W-1:0] r_a [M_T][K_MAX];
  logic signed [DATA_W-1:0] r_b [K_MAX*N_T];
  logic signed [ACC_W-1:0]  w_acc [MN];

  state_t                   w_nstate;
  logic                     w_cfg_bad, w_start, w_a_hs, w_b_hs, w_ld_hs, w_ld_tlast, w_ld_last;
  logic                     w_c_hs, w_col_last, w_k_last, w_o_last, w_pe_clr, w_pe_en;
  logic [CNT_W-1:0]         w_a_tot, w_b_tot, w_ld_tot;

  assign w_cfg_bad  = (bus.cfg_k == '0) || (bus.cfg_k > CFG_K_W'(K_MAX));
  assign w_start    = (r_state == IDLE) && bus.start;
  assign w_a_hs     = bus.s_axis_a_tvalid && r_a_tready;
  assign w_b_hs     = bus.s_axis_b_tvalid && r_b_tready;
  assign w_ld_hs    = w_a_hs || w_b_hs;
  assign w_c_hs     = r_c_tvalid && bus.m_axis_c_tready;
  assign w_a_tot    = CNT_W'(M_T) * CNT_W'(r_kcfg);
  assign w_b_tot    = CNT_W'(N_T) * CNT_W'(r_kcfg);
  assign w_ld_tot   = (r_state == LOAD_A) ? w_a_tot : w_b_tot;
  assign w_ld_tlast = (r_state == LOAD_A) ? bus.s_axis_a_tlast : bus.s_axis_b_tlast;
  assign w_ld_last  = (r_cnt == w_ld_tot - CNT_W'(1));
  assign w_col_last = (r_col == KI_W'(r_kcfg - KC_W'(1)));
  assign w_k_last   = (r_kc == KI_W'(r_kcfg - KC_W'(1)));
  assign w_o_last   = (r_oi == OI_W'(MN - 1));
  assign w_pe_clr   = w_start && !bus.cfg_acc;
  assign w_pe_en    = (r_state == COMPUTE);

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_nstate = w_cfg_bad ? DONE : LOAD_A;
      LOAD_A:  if (w_ld_hs && (w_ld_last || w_ld_tlast)) w_nstate = LOAD_B;
      LOAD_B:  if (w_ld_hs && (w_ld_last || w_ld_tlast)) w_nstate = COMPUTE;
      COMPUTE: if (w_k_last) w_nstate = OUTPUT;
      OUTPUT:  if (w_c_hs && w_o_last) w_nstate = DONE;
      DONE:    if (!bus.start) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kcfg     <= '0;
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_kc       <= '0;
      r_oi       <= '0;
      r_a_tready <= 1'b0;
      r_b_tready <= 1'b0;
      r_c_tvalid <= 1'b0;
      r_c_tlast  <= 1'b0;
      r_c_tdata  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_a_tready <= (w_nstate == LOAD_A);
      r_b_tready <= (w_nstate == LOAD_B);
      r_busy     <= !(w_nstate inside {IDLE, DONE});
      r_done     <= (w_nstate == DONE);
      unique case (r_state)
        IDLE: if (w_start) begin
          r_err  <= w_cfg_bad;
          r_kcfg <= KC_W'(bus.cfg_k);
          r_cnt  <= '0;
          r_row  <= '0;
          r_col  <= '0;
        end
        LOAD_A, LOAD_B: if (w_ld_hs) begin
          if (w_nstate != r_state) begin
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
            r_kc  <= '0;
            // Frame must end exactly on the final beat; early or missing tlast is flagged.
            if (!(w_ld_last && w_ld_tlast)) r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + RI_W'(1);
            end else begin
              r_col <= r_col + KI_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (w_k_last) begin
            r_kc <= '0;
            r_oi <= '0;
          end else begin
            r_kc <= r_kc + KI_W'(1);
          end
        end
        // First beat is loaded one cycle after COMPUTE so the last MAC has landed.
        OUTPUT: begin
          if (!r_c_tvalid) begin
            r_c_tvalid <= 1'b1;
            r_c_tdata  <= w_acc[r_oi];
            r_c_tlast  <= w_o_last;
          end else if (bus.m_axis_c_tready) begin
            if (w_o_last) begin
              r_c_tvalid <= 1'b0;
              r_c_tlast  <= 1'b0;
              r_c_tdata  <= '0;
            end else begin
              r_oi      <= r_oi + OI_W'(1);
              r_c_tdata <= w_acc[r_oi + OI_W'(1)];
              r_c_tlast <= ((r_oi + OI_W'(1)) == OI_W'(MN - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers are wiped on every start so a short (early-tlast) frame reads as zeros.
  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int i = 0; i < M_T; i++)
        for (int k = 0; k < K_MAX; k++) r_a[i][k] <= '0;
      for (int n = 0; n < K_MAX*N_T; n++) r_b[n] <= '0;
    end else begin
      if (w_a_hs) r_a[r_row][r_col] <= bus.s_axis_a_tdata;
      if (w_b_hs) r_b[r_cnt[BI_W-1:0]] <= bus.s_axis_b_tdata;
    end
  end

  for (genvar i = 0; i < M_T; i++) begin : g_row
    for (genvar j = 0; j < N_T; j++) begin : g_col
      logic [BI_W-1:0] w_b_addr;
      assign w_b_addr = BI_W'(r_kc) * BI_W'(N_T) + BI_W'(j);
      mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_pe_clr),
        .i_en  (w_pe_en),
        .i_a   (r_a[i][r_kc]),
        .i_b   (r_b[w_b_addr]),
        .o_acc (w_acc[i*N_T + j])
      );
    end
  end

  assign bus.s_axis_a_tready = r_a_tready;
  assign bus.s_axis_b_tready = r_b_tready;
  assign bus.m_axis_c_tdata  = r_c_tdata;
  assign bus.m_axis_c_tvalid = r_c_tvalid;
  assign bus.m_axis_c_tlast  = r_c_tlast;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.err             = r_err;

  a_accept_a_in_load: assert property (@(posedge clk) disable iff (rst)
    (bus.s_axis_a_tvalid && r_a_tready) |-> (r_state == LOAD_A));
  a_accept_b_in_load: assert property (@(posedge clk) disable iff (rst)
    (bus.s_axis_b_tvalid && r_b_tready) |-> (r_state == LOAD_B));
  a_c_stable: assert property (@(posedge clk) disable iff (rst)
    (r_c_tvalid && !bus.m_axis_c_tready) |=> (r_c_tvalid && $stable(r_c_tdata) && $stable(r_c_tlast)));
  a_tlast_valid: assert property (@(posedge clk) disable iff (rst) r_c_tlast |-> r_c_tvalid);
  a_compute_in_range: assert property (@(posedge clk) disable iff (rst)
    (r_state == COMPUTE) |-> (KC_W'(r_kc) < r_kcfg));
  a_compute_stay: assert property (@(posedge clk) disable iff (rst)
    (r_state == COMPUTE && !w_k_last) |=> (r_state == COMPUTE));
  a_compute_exit: assert property (@(posedge clk) disable iff (rst)
    (r_state == COMPUTE && w_k_last) |=> (r_state == OUTPUT));

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed bench for matmul_tile_engine with hand-computed C tiles.
module tb_matmul_tile_engine;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 48;
  localparam int M_T    = 2;
  localparam int N_T    = 2;
  localparam int K_MAX  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_tile_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  matmul_tile_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .M_T(M_T), .N_T(N_T), .K_MAX(K_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     tests = 0;
  int     fails = 0;
  longint c_got [4];
  int     c_n, c_lastpos, c_stab, c_stalls;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int k, input bit acc);
    bus.cfg_k   = 16'(k);
    bus.cfg_acc = acc;
    bus.start   = 1'b1;
    @(negedge clk);
  endtask

  // Drives n beats on A (is_b=0) or B (is_b=1), tlast on beat index last_at.
  task automatic send(input bit is_b, input int v[8], input int n, input int last_at);
    int w;
    for (int i = 0; i < n; i++) begin
      if (is_b) begin
        bus.s_axis_b_tdata  = v[i];
        bus.s_axis_b_tvalid = 1'b1;
        bus.s_axis_b_tlast  = (i == last_at);
      end else begin
        bus.s_axis_a_tdata  = v[i];
        bus.s_axis_a_tvalid = 1'b1;
        bus.s_axis_a_tlast  = (i == last_at);
      end
      w = 0;
      while (!(is_b ? bus.s_axis_b_tready : bus.s_axis_a_tready) && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        chk(is_b ? "b_tready_timeout" : "a_tready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    bus.s_axis_a_tvalid = 1'b0;
    bus.s_axis_a_tlast  = 1'b0;
    bus.s_axis_b_tvalid = 1'b0;
    bus.s_axis_b_tlast  = 1'b0;
  endtask

  // Collects up to 4 C beats with tready following pat, and watches stall stability.
  task automatic collect(input logic [31:0] pat);
    logic             rdy, pv, pl;
    logic [ACC_W-1:0] pd;
    c_n = 0; c_lastpos = -1; c_stab = 0; c_stalls = 0;
    pv = 1'b0; pl = 1'b0; pd = '0;
    for (int i = 0; i < 4; i++) c_got[i] = -999;
    for (int cyc = 0; cyc < 200 && c_n < 4; cyc++) begin
      rdy = pat[5'(cyc)];
      bus.m_axis_c_tready = rdy;
      if (pv) begin
        c_stalls++;
        if (!bus.m_axis_c_tvalid || bus.m_axis_c_tdata !== pd || bus.m_axis_c_tlast !== pl) c_stab++;
      end
      pv = bus.m_axis_c_tvalid && !rdy;
      pd = bus.m_axis_c_tdata;
      pl = bus.m_axis_c_tlast;
      if (bus.m_axis_c_tvalid && rdy) begin
        c_got[c_n] = longint'(bus.m_axis_c_tdata);
        if (bus.m_axis_c_tlast) c_lastpos = c_n;
        c_n++;
      end
      @(negedge clk);
    end
    bus.m_axis_c_tready = 1'b0;
  endtask

  task automatic check_c(input string tag, input longint e0, input longint e1,
                         input longint e2, input longint e3);
    chk({tag, "_beats"}, c_n, 4);
    chk({tag, "_c0"}, c_got[0], e0);
    chk({tag, "_c1"}, c_got[1], e1);
    chk({tag, "_c2"}, c_got[2], e2);
    chk({tag, "_c3"}, c_got[3], e3);
    chk({tag, "_tlast_pos"}, c_lastpos, 3);
    chk({tag, "_no_extra_beat"}, bus.m_axis_c_tvalid, 0);
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (!bus.done && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(tag, bus.done, 1);
  endtask

  initial begin
    int w;
    bus.s_axis_a_tdata = '0; bus.s_axis_a_tvalid = 1'b0; bus.s_axis_a_tlast = 1'b0;
    bus.s_axis_b_tdata = '0; bus.s_axis_b_tvalid = 1'b0; bus.s_axis_b_tlast = 1'b0;
    bus.m_axis_c_tready = 1'b0;
    bus.cfg_k = '0; bus.cfg_acc = 1'b0; bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_a_tready", bus.s_axis_a_tready, 0);
    chk("rst_b_tready", bus.s_axis_b_tready, 0);
    chk("rst_c_tvalid", bus.m_axis_c_tvalid, 0);
    chk("rst_c_tlast",  bus.m_axis_c_tlast, 0);
    chk("rst_c_tdata",  bus.m_axis_c_tdata, 0);
    chk("rst_busy",     bus.busy, 0);
    chk("rst_done",     bus.done, 0);
    chk("rst_err",      bus.err, 0);

    // Run 1: K=3, C = A*B
    start_run(3, 1'b0);
    chk("r1_a_tready_latency", bus.s_axis_a_tready, 1);
    chk("r1_busy", bus.busy, 1);
    chk("r1_b_tready_idle", bus.s_axis_b_tready, 0);
    send(1'b0, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5);
    chk("r1_a_tready_drop", bus.s_axis_a_tready, 0);
    chk("r1_b_tready", bus.s_axis_b_tready, 1);
    send(1'b1, '{1, 0, 0, 1, 1, 1, 0, 0}, 6, 5);
    w = 0;
    while (!bus.m_axis_c_tvalid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("r1_c_latency_ok", (w <= 5) ? 1 : 0, 1);
    collect(32'hFFFF_FFFF);
    check_c("r1", 4, 5, 10, 11);
    wait_done("r1_done");
    chk("r1_err", bus.err, 0);
    chk("r1_busy_done", bus.busy, 0);
    repeat (2) @(negedge clk);
    chk("r1_done_held", bus.done, 1);
    chk("r1_no_retrigger", bus.s_axis_a_tready, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("r1_back_idle", bus.done, 0);

    // Run 2: same data, accumulate into previous C
    start_run(3, 1'b1);
    send(1'b0, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5);
    send(1'b1, '{1, 0, 0, 1, 1, 1, 0, 0}, 6, 5);
    collect(32'hFFFF_FFFF);
    check_c("r2", 8, 10, 20, 22);
    wait_done("r2_done");
    chk("r2_err", bus.err, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // Run 3: signed data, backpressure on C
    start_run(2, 1'b0);
    send(1'b0, '{-1, 2, 3, -4, 0, 0, 0, 0}, 4, 3);
    send(1'b1, '{5, -6, 7, 8, 0, 0, 0, 0}, 4, 3);
    collect(32'hB6DB_6D97);
    check_c("r3", 9, 22, -13, -50);
    chk("r3_stalls_seen", (c_stalls > 0) ? 1 : 0, 1);
    chk("r3_stall_stable", c_stab, 0);
    wait_done("r3_done");
    bus.start = 1'b0;
    @(negedge clk);

    // Run 4: A frame ends early on beat 2 -> rest of A is zero
    start_run(3, 1'b0);
    send(1'b0, '{1, 2, 0, 0, 0, 0, 0, 0}, 2, 1);
    chk("r4_a_tready_drop", bus.s_axis_a_tready, 0);
    chk("r4_b_tready", bus.s_axis_b_tready, 1);
    chk("r4_err_set", bus.err, 1);
    send(1'b1, '{1, 0, 0, 1, 1, 1, 0, 0}, 6, 5);
    collect(32'hFFFF_FFFF);
    check_c("r4", 1, 2, 0, 0);
    wait_done("r4_done");
    chk("r4_err_sticky", bus.err, 1);
    bus.start = 1'b0;
    @(negedge clk);

    // Run 5: illegal cfg_k values
    start_run(0, 1'b0);
    chk("k0_done", bus.done, 1);
    chk("k0_err", bus.err, 1);
    chk("k0_a_tready", bus.s_axis_a_tready, 0);
    chk("k0_busy", bus.busy, 0);
    chk("k0_c_tvalid", bus.m_axis_c_tvalid, 0);
    bus.start = 1'b0;
    @(negedge clk);
    start_run(K_MAX + 1, 1'b1);
    chk("kbig_done", bus.done, 1);
    chk("kbig_err", bus.err, 1);
    chk("kbig_a_tready", bus.s_axis_a_tready, 0);
    chk("kbig_c_tvalid", bus.m_axis_c_tvalid, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // Run 6: reset in COMPUTE, then a fresh accumulate run sees a cleared C
    start_run(3, 1'b0);
    chk("r6_err_cleared", bus.err, 0);
    send(1'b0, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5);
    send(1'b1, '{1, 0, 0, 1, 1, 1, 0, 0}, 6, 5);
    chk("r6_busy_in_compute", bus.busy, 1);
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("r6_rst_busy", bus.busy, 0);
    chk("r6_rst_done", bus.done, 0);
    chk("r6_rst_a_tready", bus.s_axis_a_tready, 0);
    chk("r6_rst_b_tready", bus.s_axis_b_tready, 0);
    chk("r6_rst_c_tvalid", bus.m_axis_c_tvalid, 0);
    chk("r6_rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(3, 1'b1);
    send(1'b0, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5);
    send(1'b1, '{1, 0, 0, 1, 1, 1, 0, 0}, 6, 5);
    collect(32'hFFFF_FFFF);
    check_c("r6", 4, 5, 10, 11);
    wait_done("r6_done");
    bus.start = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
